// File: rtl/multi_pulse_sync_pkg.sv
// Shared types for the multi-channel pulse synchroniser.
package multi_pulse_sync_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } ch_state_t;

endpackage

// File: rtl/multi_pulse_sync_ch.sv
// One synchroniser channel: sync chain, optional glitch filter, edge detect,
// pulse stretch / ack-hold FSM and sticky overrun flag.
module multi_pulse_sync_ch
  import multi_pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = 3,
  parameter int FILTER_CYCLES = 0,
  parameter int EDGE_MODE     = 0,
  parameter int STRETCH       = 4,
  parameter int ACK_MODE      = 0,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  input  logic ack_in,
  input  logic overrun_clr,
  output logic pulse_out,
  output logic level_out,
  output logic overrun
);

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  localparam int FCW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
  localparam int SCW = (STRETCH > 1) ? $clog2(STRETCH + 1) : 1;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic synced;
  logic filt_level;
  logic filt_d;
  logic rise_ev;
  logic fall_ev;
  logic ev;

  ch_state_t      state_q, state_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic           ovr_q, ovr_d;
  logic           ovr_set;

  always_ff @(posedge clk_in) begin
    if (rst) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES > 0) begin : g_filter
      logic [FCW-1:0] flt_cnt;
      logic           flt_q;

      // Accept a new level only after FILTER_CYCLES consecutive cycles of disagreement.
      always_ff @(posedge clk_in) begin
        if (rst) begin
          flt_q   <= INIT_LEVEL;
          flt_cnt <= '0;
        end else if (synced == flt_q) begin
          flt_cnt <= '0;
        end else if (flt_cnt == FCW'(FILTER_CYCLES - 1)) begin
          flt_q   <= synced;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + FCW'(1);
        end
      end

      assign filt_level = flt_q;
    end else begin : g_bypass
      assign filt_level = synced;
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst) filt_d <= INIT_LEVEL;
    else     filt_d <= filt_level;
  end

  assign rise_ev = filt_level & ~filt_d;
  assign fall_ev = ~filt_level & filt_d;
  assign ev = (EDGE_MODE == EDGE_RISE) ? rise_ev :
              (EDGE_MODE == EDGE_FALL) ? fall_ev :
              (EDGE_MODE == EDGE_BOTH) ? (rise_ev | fall_ev) : 1'b0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  // An event that cannot start a new pulse is lost and flagged; in ack mode an
  // event coinciding with the ack re-arms the pulse instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_ACTIVE;
          cnt_d   = SCW'(STRETCH - 1);
        end
      end
      ST_ACTIVE: begin
        if (ACK_MODE == 0) begin
          ovr_set = ev;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - SCW'(1);
        end else if (ack_in) begin
          if (!ev) state_d = ST_IDLE;
        end else begin
          ovr_set = ev;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ovr_d = ovr_set | (ovr_q & ~overrun_clr);
  end

  assign pulse_out = (state_q == ST_ACTIVE);
  assign level_out = filt_level;
  assign overrun   = ovr_q;

endmodule

// File: rtl/multi_pulse_sync.sv
// Multi-channel asynchronous event synchroniser into BUS_CLK; one
// multi_pulse_sync_ch per channel.
module multi_pulse_sync
  import multi_pulse_sync_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 3,
  parameter int FILTER_CYCLES = 0,
  parameter int EDGE_MODE     = 0,
  parameter int STRETCH       = 4,
  parameter int ACK_MODE      = 0,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [CHANNELS-1:0] ack_in,
  input  logic [CHANNELS-1:0] overrun_clr,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] overrun
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      multi_pulse_sync_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .EDGE_MODE    (EDGE_MODE),
        .STRETCH      (STRETCH),
        .ACK_MODE     (ACK_MODE),
        .INIT_LEVEL   (INIT_LEVEL)
      ) u_ch (
        .clk_in     (BUS_CLK),
        .rst        (BUS_RST),
        .async_in   (async_in[i]),
        .ack_in     (ack_in[i]),
        .overrun_clr(overrun_clr[i]),
        .pulse_out  (pulse_out[i]),
        .level_out  (level_out[i]),
        .overrun    (overrun[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Directed bench for multi_pulse_sync: four instances cover default, filtered,
// both-edge/1-cycle-stretch and ack-hold configurations.
module tb_multi_pulse_sync;

  logic clk;
  logic rst;

  logic [3:0] async_def, ack_def, clr_def, pulse_def, level_def, ovr_def;
  logic [3:0] async_flt, ack_flt, clr_flt, pulse_flt, level_flt, ovr_flt;
  logic [3:0] async_both, ack_both, clr_both, pulse_both, level_both, ovr_both;
  logic [3:0] async_ack, ack_ack, clr_ack, pulse_ack, level_ack, ovr_ack;

  int checks = 0;
  int errors = 0;

  multi_pulse_sync dut_def (
    .BUS_CLK(clk), .BUS_RST(rst), .async_in(async_def), .ack_in(ack_def),
    .overrun_clr(clr_def), .pulse_out(pulse_def), .level_out(level_def), .overrun(ovr_def)
  );

  multi_pulse_sync #(.FILTER_CYCLES(3)) dut_flt (
    .BUS_CLK(clk), .BUS_RST(rst), .async_in(async_flt), .ack_in(ack_flt),
    .overrun_clr(clr_flt), .pulse_out(pulse_flt), .level_out(level_flt), .overrun(ovr_flt)
  );

  multi_pulse_sync #(.EDGE_MODE(2), .STRETCH(1)) dut_both (
    .BUS_CLK(clk), .BUS_RST(rst), .async_in(async_both), .ack_in(ack_both),
    .overrun_clr(clr_both), .pulse_out(pulse_both), .level_out(level_both), .overrun(ovr_both)
  );

  multi_pulse_sync #(.ACK_MODE(1)) dut_ack (
    .BUS_CLK(clk), .BUS_RST(rst), .async_in(async_ack), .ack_in(ack_ack),
    .overrun_clr(clr_ack), .pulse_out(pulse_ack), .level_out(level_ack), .overrun(ovr_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    {async_def, ack_def, clr_def}    = '0;
    {async_flt, ack_flt, clr_flt}    = '0;
    {async_both, ack_both, clr_both} = '0;
    {async_ack, ack_ack, clr_ack}    = '0;
    waitCycles(3);

    checkOutput("rst_pulse_def", 32'(pulse_def), 0);
    checkOutput("rst_level_def", 32'(level_def), 0);
    checkOutput("rst_ovr_def",   32'(ovr_def), 0);
    checkOutput("rst_pulse_ack", 32'(pulse_ack), 0);

    rst = 1'b0;
    waitCycles(2);

    // Default config: rising edge, pulse at cycle 4 for 4 cycles
    async_def[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      waitCycles(1);
      checkOutput($sformatf("t1_pulse_c%0d", i), 32'(pulse_def[0]), 32'(i >= 4 && i <= 7));
      checkOutput($sformatf("t1_quiet_c%0d", i), 32'(pulse_def[3:1]), 0);
    end
    checkOutput("t1_level", 32'(level_def[0]), 1);
    checkOutput("t1_ovr", 32'(ovr_def), 0);
    async_def[0] = 1'b0;
    waitCycles(6);

    // Filter of 3: a 2-cycle glitch is suppressed
    async_flt[0] = 1'b1;
    waitCycles(2);
    async_flt[0] = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      waitCycles(1);
      checkOutput($sformatf("t2_glitch_pulse_c%0d", i), 32'(pulse_flt[0]), 0);
      checkOutput($sformatf("t2_glitch_level_c%0d", i), 32'(level_flt[0]), 0);
    end
    // 6-cycle high passes; pulse at 3+3+1 = 7
    async_flt[0] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      waitCycles(1);
      checkOutput($sformatf("t2_pulse_c%0d", i), 32'(pulse_flt[0]), 32'(i >= 7));
      checkOutput($sformatf("t2_level_c%0d", i), 32'(level_flt[0]), 32'(i >= 6));
      if (i == 6) async_flt[0] = 1'b0;
    end
    waitCycles(12);

    // Both edges, 1-cycle stretch: pulses at 4 and 12
    async_both[0] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      waitCycles(1);
      checkOutput($sformatf("t3_pulse_c%0d", i), 32'(pulse_both[0]), 32'(i == 4 || i == 12));
      if (i == 8) async_both[0] = 1'b0;
    end

    // Ack mode: hold, overrun, clear, clear-vs-set, ack release
    async_ack[0] = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      waitCycles(1);
      case (i)
        4:  checkOutput("t4_pulse_rise", 32'(pulse_ack[0]), 1);
        6:  async_ack[0] = 1'b0;
        8:  async_ack[0] = 1'b1;
        11: checkOutput("t4_ovr_before", 32'(ovr_ack[0]), 0);
        12: begin
          checkOutput("t4_ovr_set", 32'(ovr_ack[0]), 1);
          checkOutput("t4_pulse_held", 32'(pulse_ack[0]), 1);
        end
        13: begin
          checkOutput("t4_ovr_sticky", 32'(ovr_ack[0]), 1);
          clr_ack[0] = 1'b1;
        end
        14: begin
          checkOutput("t4_ovr_cleared", 32'(ovr_ack[0]), 0);
          clr_ack[0]   = 1'b0;
          async_ack[0] = 1'b0;
        end
        16: async_ack[0] = 1'b1;
        19: begin
          checkOutput("t4_pulse_c19", 32'(pulse_ack[0]), 1);
          clr_ack[0] = 1'b1;
        end
        20: begin
          checkOutput("t4_ovr_set_wins", 32'(ovr_ack[0]), 1);
          checkOutput("t4_pulse_c20", 32'(pulse_ack[0]), 1);
          clr_ack[0] = 1'b0;
          ack_ack[0] = 1'b1;
        end
        21: begin
          checkOutput("t4_pulse_after_ack", 32'(pulse_ack[0]), 0);
          ack_ack[0] = 1'b0;
          clr_ack[0] = 1'b1;
        end
        22: begin
          checkOutput("t4_ovr_final", 32'(ovr_ack[0]), 0);
          clr_ack[0] = 1'b0;
        end
        default: ;
      endcase
    end

    // Ack mode: event in the same cycle as ack re-arms the pulse
    async_ack[0] = 1'b0;
    waitCycles(6);
    async_ack[0] = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      waitCycles(1);
      case (i)
        4:  checkOutput("t5_pulse_rise", 32'(pulse_ack[0]), 1);
        5:  async_ack[0] = 1'b0;
        7:  async_ack[0] = 1'b1;
        10: ack_ack[0] = 1'b1;
        11: begin
          checkOutput("t5_pulse_rearm", 32'(pulse_ack[0]), 1);
          checkOutput("t5_no_ovr", 32'(ovr_ack[0]), 0);
          ack_ack[0] = 1'b0;
        end
        12: begin
          checkOutput("t5_pulse_still", 32'(pulse_ack[0]), 1);
          ack_ack[0] = 1'b1;
        end
        13: begin
          checkOutput("t5_pulse_drop", 32'(pulse_ack[0]), 0);
          ack_ack[0] = 1'b0;
        end
        default: ;
      endcase
    end

    // Overrun in stretch mode, then reset mid-pulse, then INIT_LEVEL edge
    async_def[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      waitCycles(1);
      if (i == 1) async_def[0] = 1'b0;
      if (i == 2) async_def[0] = 1'b1;
      if (i == 4) checkOutput("t6_pulse_rise", 32'(pulse_def[0]), 1);
    end
    checkOutput("t6_ovr_stretch", 32'(ovr_def[0]), 1);
    checkOutput("t6_pulse_c6", 32'(pulse_def[0]), 1);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t6_rst_pulse", 32'(pulse_def[0]), 0);
    checkOutput("t6_rst_ovr", 32'(ovr_def[0]), 0);
    checkOutput("t6_rst_level", 32'(level_def[0]), 0);
    waitCycles(1);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      waitCycles(1);
      if (i == 3) begin
        checkOutput("t6_init_pulse_c3", 32'(pulse_def[0]), 0);
        checkOutput("t6_init_level_c3", 32'(level_def[0]), 1);
      end
      if (i == 4) checkOutput("t6_init_pulse_c4", 32'(pulse_def[0]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
